kbd_event_fifo: RTL and testbench
=================================

Name: kbd_event_fifo

Overview:
- Sits directly downstream of the keyboard/mouse poller in the monitor-clock domain.
- Turns each new response from the poller into exactly one tagged event: a rising edge on the poller's data-ready level becomes a 17-bit entry {is_mouse, data[15:0]}.
- Queues events in a first-word-fall-through FIFO for the host-side register/DMA logic, which drains them with a valid/ready handshake.
- Flags overflow when a new event arrives and the queue is full; optionally discards zero-motion mouse reports.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- DROP_ZERO_MOUSE, 1, when 1 a mouse event with data == 16'h0000 is discarded and not counted as an event.

Ports:
- clk  input  1  monitor clock, the same clock as the poller.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  poller data-ready level; high for one or more cycles per response.
- in_is_mouse  input  1  0 = keyboard word, 1 = mouse word; stable while in_valid is high.
- in_data  input  16  keyboard/mouse word; stable while in_valid is high.
- out_valid  output  1  head entry is available.
- out_data  output  17  head entry {is_mouse, data}.
- out_ready  input  1  consumer accepts the head entry this cycle.
- count  output  $clog2(DEPTH)+1  number of stored entries.
- overflow  output  1  sticky; set when an event is dropped because the FIFO is full.
- overflow_clear  input  1  clears overflow.

Behaviour:
- Clock and reset:
  - Single clock; reset is synchronous and active-high.
  - Reset values: out_valid=0, out_data=0, count=0, overflow=0, read/write pointers=0, in_valid_q=1.
- Edge detect:
  - push_req = in_valid & ~in_valid_q, where in_valid_q is in_valid registered on clk.
  - One event per high period, whatever its length.
  - in_valid_q resets to 1, so a level already high when reset deasserts is not captured. Capture resumes after in_valid next goes low.
- Filter: when DROP_ZERO_MOUSE=1 and in_is_mouse=1 and in_data=16'h0000, push_req is suppressed. Overflow is not affected.
- Write: {in_is_mouse, in_data} is sampled in the push_req cycle.
- Read and handshake:
  - FWFT: out_data always shows the head entry; out_data=0 when empty.
  - Pop = out_valid & out_ready.
  - out_valid must not depend combinationally on out_ready.
- Latency: an event pushed into an empty FIFO in cycle N has out_valid=1 in cycle N+1.
- Count: next = count + push_accepted - pop.
- Full (count==DEPTH):
  - Push without a pop in the same cycle: the entry is dropped, overflow is set, count and pointers are unchanged.
  - Push with a pop in the same cycle: both occur, no overflow, count stays DEPTH.
- Empty: out_ready is ignored and pointers hold.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. Full/empty is decided from count.
- overflow:
  - When a set event and overflow_clear occur in the same cycle, set wins and overflow stays 1.
  - overflow never clears on its own.
- Reset mid-operation: all entries are flushed and overflow is cleared. An in_valid pulse that is high across the reset edge is ignored.
- No state machine beyond the edge detector and FIFO. Storage is a register array; no RAM inference is required.

Decomposition:
- Package kbd_pkg holds:
  - KBD_WORD_W=16 and KBD_EVENT_W=17.
  - Event field positions: IS_MOUSE bit=16, DATA=[15:0].
  - MOUSE_NULL=16'h0000.
- Sub-module sync_fifo_fwft (params WIDTH, DEPTH; ports clk, reset, push, din, pop, dout, count, full, empty). kbd_event_fifo adds the edge detect, filter and overflow logic around it.

Test Plan:
- Single keyboard event: in_valid high for 3 cycles with in_is_mouse=0, in_data=16'h1A29 → exactly one entry; out_valid high 1 cycle after the edge; out_data=17'h01A29; count=1; after pop, count=0.
- Mouse null filter: DROP_ZERO_MOUSE=1, mouse event with 16'h0000, then mouse event with 16'h0302 → only 17'h10302 is queued; count=1; overflow=0.
- Fill and overflow: DEPTH=8, 9 keyboard events with data 0..8 and out_ready=0 → count=8, overflow=1; reads return 0..7 in order; event 8 is absent.
- Full with simultaneous push/pop: FIFO full, push 16'h00AA in the same cycle as a pop → count stays 8, overflow=0, 16'h00AA is the last entry read.
- Overflow priority: overflow_clear=1 in the same cycle as a dropped push → overflow remains 1; overflow_clear alone on the next cycle → overflow=0.
- Reset with in_valid held high: assert reset with in_valid=1, deassert reset with in_valid still 1 → no entry is pushed; the next low-to-high transition of in_valid pushes one entry.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared widths and field positions for keyboard/mouse poller events.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kbd_pkg;

    localparam int KBD_WORD_W  = 16;
    localparam int KBD_EVENT_W = 17;

    // Event layout: {is_mouse, data[15:0]}
    localparam int EV_IS_MOUSE_BIT = 16;
    localparam int EV_DATA_MSB     = 15;
    localparam int EV_DATA_LSB     = 0;

    // A mouse report with no motion and no buttons carries no information.
    localparam logic [KBD_WORD_W-1:0] MOUSE_NULL = 16'h0000;

    function automatic logic [KBD_EVENT_W-1:0] make_event(
        input logic                  is_mouse,
        input logic [KBD_WORD_W-1:0] data
    );
        return {is_mouse, data};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through register FIFO; dout shows the head entry, 0 when empty.
// Latency: a push into an empty FIFO is visible on dout/~empty the next cycle.
// Backpressure: push while full is ignored unless a pop happens the same cycle; pop while empty is ignored.
//
// Ports: clk, reset (sync, active-high), push/din write side, pop/dout read side,
//        count (entries stored), full, empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // When full, a simultaneous pop frees the slot the push lands in.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: dout is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/kbd_event_fifo.sv
// Turns each rising edge of the poller's data-ready level into one tagged event queued in a FWFT FIFO.
// Latency: event captured in cycle N is presented on out_valid/out_data in cycle N+1.
// Backpressure: consumer drains with out_valid/out_ready; events arriving while full are dropped and flagged in sticky overflow.
//
// Ports: clk, reset (sync, active-high); in_valid/in_is_mouse/in_data from the poller;
//        out_valid/out_data/out_ready to the host; count; overflow with overflow_clear.
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter bit DROP_ZERO_MOUSE = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_is_mouse,
    input  logic [KBD_WORD_W-1:0]    in_data,
    output logic                     out_valid,
    output logic [KBD_EVENT_W-1:0]   out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     overflow_clear
);

    logic in_valid_q;
    logic overflow_q;
    logic overflow_d;
    logic edge_det;
    logic is_null_mouse;
    logic push_req;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic overflow_set;

    // in_valid_q resets high so a level already asserted across reset is not
    // mistaken for a fresh response; capture resumes after in_valid drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_valid_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            in_valid_q <= in_valid;
            overflow_q <= overflow_d;
        end
    end

    assign edge_det      = in_valid & ~in_valid_q;
    assign is_null_mouse = DROP_ZERO_MOUSE & in_is_mouse & (in_data == MOUSE_NULL);
    assign push_req      = edge_det & ~is_null_mouse;

    // out_valid is derived from stored count only, never from out_ready.
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign overflow_set = push_req & fifo_full & ~pop;

    always_comb begin
        overflow_d = overflow_q;
        if (overflow_set)        overflow_d = 1'b1;
        else if (overflow_clear) overflow_d = 1'b0;
    end

    assign overflow = overflow_q;

    sync_fifo_fwft #(
        .WIDTH (KBD_EVENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (make_event(in_is_mouse, in_data)),
        .pop   (pop),
        .dout  (out_data),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_kbd_event_fifo.sv
module tb_kbd_event_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_is_mouse;
    logic [15:0] in_data;
    logic        out_valid;
    logic [16:0] out_data;
    logic        out_ready;
    logic [3:0]  count;
    logic        overflow;
    logic        overflow_clear;

    int tests_run = 0;
    int tests_failed = 0;

    kbd_event_fifo #(.DEPTH(8), .DROP_ZERO_MOUSE(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_is_mouse    (in_is_mouse),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .count          (count),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One poller response: level high for one cycle, then low for one cycle.
    task automatic send_event(input logic mouse, input logic [15:0] d);
        in_is_mouse = mouse;
        in_data     = d;
        in_valid    = 1'b1;
        step();
        in_valid    = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_is_mouse = 1'b0; in_data = 16'h0;
        out_ready = 1'b0; overflow_clear = 1'b0;
        step(); step(); step();
        tests_run++;
        if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || out_data !== 17'h0) begin
            tests_failed++;
            $display("FAIL reset_state: out_valid=%b count=%0d overflow=%b out_data=%h, want 0 0 0 00000",
                     out_valid, count, overflow, out_data);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_kbd();
        in_is_mouse = 1'b0; in_data = 16'h1A29; in_valid = 1'b1;
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 17'h01A29 || count !== 4'd1) begin
            tests_failed++;
            $display("FAIL single_kbd_latency: out_valid=%b out_data=%h count=%0d, want 1 01a29 1",
                     out_valid, out_data, count);
        end
        step(); step();
        in_valid = 1'b0;
        step();
        tests_run++;
        if (count !== 4'd1) begin
            tests_failed++;
            $display("FAIL single_kbd_one_event: count=%0d, want 1", count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests_run++;
        if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 17'h0) begin
            tests_failed++;
            $display("FAIL single_kbd_pop: count=%0d out_valid=%b out_data=%h, want 0 0 00000",
                     count, out_valid, out_data);
        end
    endtask

    task automatic test_mouse_filter();
        send_event(1'b1, 16'h0000);
        tests_run++;
        if (count !== 4'd0) begin
            tests_failed++;
            $display("FAIL mouse_null_dropped: count=%0d, want 0", count);
        end
        send_event(1'b1, 16'h0302);
        tests_run++;
        if (count !== 4'd1 || out_data !== 17'h10302 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL mouse_event: count=%0d out_data=%h overflow=%b, want 1 10302 0",
                     count, out_data, overflow);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 9; i++) send_event(1'b0, 16'(i));
        tests_run++;
        if (count !== 4'd8 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_overflow: count=%0d overflow=%b, want 8 1", count, overflow);
        end
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_clear: overflow=%b, want 0", overflow);
        end
    endtask

    task automatic test_overflow_priority();
        // FIFO still full: a new edge collides with overflow_clear.
        in_is_mouse = 1'b0; in_data = 16'h0099; in_valid = 1'b1; overflow_clear = 1'b1;
        step();
        tests_run++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            tests_failed++;
            $display("FAIL overflow_set_wins: overflow=%b count=%0d, want 1 8", overflow, count);
        end
        in_valid = 1'b0;
        step();
        overflow_clear = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_clear_alone: overflow=%b, want 0", overflow);
        end
    endtask

    task automatic test_read_order();
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 17'(i)) begin
                tests_failed++;
                $display("FAIL read_order[%0d]: out_valid=%b out_data=%h, want 1 %h",
                         i, out_valid, out_data, 17'(i));
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        tests_run++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_drained: count=%0d out_valid=%b, want 0 0", count, out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [16:0] exp;
        for (int i = 0; i < 8; i++) send_event(1'b0, 16'h0010 + 16'(i));
        in_is_mouse = 1'b0; in_data = 16'h00AA; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if (count !== 4'd8 || overflow !== 1'b0 || out_data !== 17'h00011) begin
            tests_failed++;
            $display("FAIL full_push_pop: count=%0d overflow=%b out_data=%h, want 8 0 00011",
                     count, overflow, out_data);
        end
        step();
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 17'h00011 + 17'(i) : 17'h000AA;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                tests_failed++;
                $display("FAIL full_push_pop_read[%0d]: out_valid=%b out_data=%h, want 1 %h",
                         i, out_valid, out_data, exp);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        tests_run++;
        if (count !== 4'd0) begin
            tests_failed++;
            $display("FAIL full_push_pop_drained: count=%0d, want 0", count);
        end
    endtask

    task automatic test_reset_held_valid();
        send_event(1'b0, 16'h0055);
        send_event(1'b0, 16'h0066);
        in_is_mouse = 1'b0; in_data = 16'h0077;
        in_valid = 1'b1; reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step(); step(); step();
        tests_run++;
        if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_held_valid: count=%0d out_valid=%b overflow=%b, want 0 0 0",
                     count, out_valid, overflow);
        end
        in_valid = 1'b0;
        step();
        in_data = 16'h7E01; in_valid = 1'b1;
        step();
        tests_run++;
        if (count !== 4'd1 || out_data !== 17'h07E01) begin
            tests_failed++;
            $display("FAIL reset_recapture: count=%0d out_data=%h, want 1 07e01", count, out_data);
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_kbd();
        test_mouse_filter();
        test_fill_overflow();
        test_overflow_priority();
        test_read_order();
        test_full_push_pop();
        test_reset_held_valid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
